// File: rtl/expr_vector_sequencer.sv
// LFSR stimulus sequencer with MISR response compaction for regression of an
// expression datapath. One run issues num_vec vectors back-to-back and reports a signature.
`timescale 1ns/1ps
module expr_vector_sequencer #(
    parameter int STIM_W  = 60,
    parameter int RESP_W  = 90,
    parameter int DUT_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [63:0]       seed,
    output logic [STIM_W-1:0] stim,
    output logic              stim_valid,
    input  logic [RESP_W-1:0] y,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] signature
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [RESP_W-1:0] MISR_POLY = {{(RESP_W-4){1'b0}}, 4'hD};
    localparam int DRAIN_LAST = (DUT_LAT > 0) ? DUT_LAT - 1 : 0;

    function automatic logic [63:0] lfsr_next(input logic [63:0] l);
        lfsr_next = {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
    endfunction

    function automatic logic [RESP_W-1:0] misr_next(input logic [RESP_W-1:0] s,
                                                    input logic [RESP_W-1:0] d);
        misr_next = {s[RESP_W-2:0], 1'b0} ^ (s[RESP_W-1] ? MISR_POLY : {RESP_W{1'b0}}) ^ d;
    endfunction

    state_t            state_r, state_s;
    logic [63:0]       lfsr_r;
    logic [CNT_W-1:0]  issued_r;
    logic [CNT_W-1:0]  num_vec_r;
    logic [2:0]        drain_cnt_r;
    logic [RESP_W-1:0] sig_r;
    logic              stim_valid_r, busy_r, done_r;
    logic              last_vec_s, abort_hit_s, resp_valid_s;

    assign last_vec_s  = (issued_r == (num_vec_r - {{(CNT_W-1){1'b0}}, 1'b1}));
    assign abort_hit_s = abort && ((state_r == RUN) || (state_r == DRAIN));

    // Next-state decode; abort outranks the end-of-run transition.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (num_vec != {CNT_W{1'b0}}) ? RUN : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (last_vec_s) begin
                    state_s = (DUT_LAT > 0) ? DRAIN : DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (drain_cnt_r == DRAIN_LAST[2:0]) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, stimulus generator, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            lfsr_r       <= 64'h0;
            issued_r     <= {CNT_W{1'b0}};
            num_vec_r    <= {CNT_W{1'b0}};
            drain_cnt_r  <= 3'd0;
            stim_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            stim_valid_r <= (state_s == RUN);
            busy_r       <= (state_s == RUN) || (state_s == DRAIN);
            done_r       <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        num_vec_r   <= num_vec;
                        issued_r    <= {CNT_W{1'b0}};
                        drain_cnt_r <= 3'd0;
                        if (num_vec != {CNT_W{1'b0}}) begin
                            lfsr_r <= (seed == 64'h0) ? 64'h1 : seed;
                        end
                    end
                end
                RUN: begin
                    issued_r <= issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    // Freeze on the final vector so stim holds its last value afterwards.
                    if (state_s == RUN) begin
                        lfsr_r <= lfsr_next(lfsr_r);
                    end
                end
                DRAIN:   drain_cnt_r <= drain_cnt_r + 3'd1;
                default: drain_cnt_r <= 3'd0;
            endcase
        end
    end

    generate
        if (DUT_LAT > 0) begin : g_vpipe
            logic [DUT_LAT-1:0] vpipe_r;
            // Delays stim_valid to line up with the datapath response.
            always_ff @(posedge clk) begin
                if (reset || abort_hit_s) begin
                    vpipe_r <= {DUT_LAT{1'b0}};
                end else begin
                    vpipe_r[0] <= stim_valid_r;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vpipe_r[i] <= vpipe_r[i-1];
                    end
                end
            end
            assign resp_valid_s = vpipe_r[DUT_LAT-1];
        end else begin : g_novpipe
            assign resp_valid_s = stim_valid_r;
        end
    endgenerate

    // Signature register: cleared by an accepted start, folds y only on valid responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_r <= {RESP_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            sig_r <= {RESP_W{1'b0}};
        end else if (resp_valid_s) begin
            sig_r <= misr_next(sig_r, y);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign stim       = lfsr_r[STIM_W-1:0];
    assign stim_valid = stim_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign signature  = sig_r;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Bench for expr_vector_sequencer: a combinational (DUT_LAT=0) and a pipelined (DUT_LAT=2)
// instance checked against a sequence-level model of the stimulus and signature.
`timescale 1ns/1ps
module tb_expr_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, start0, abort0, sv0, busy0, done0;
    logic [15:0] nv0;
    logic [63:0] sd0;
    logic [59:0] stim0;
    logic [89:0] y0, sig0;
    logic        rst2, start2, abort2, sv2, busy2, done2;
    logic [15:0] nv2;
    logic [63:0] sd2;
    logic [59:0] stim2;
    logic [89:0] y2, yp1, sig2;
    int          mode0 = 0, mode2 = 0;
    int          n_cmp = 0, n_fail = 0;

    expr_vector_sequencer #(.DUT_LAT(0)) dut0 (
        .clk(clk), .reset(rst0), .start(start0), .abort(abort0), .num_vec(nv0), .seed(sd0),
        .stim(stim0), .stim_valid(sv0), .y(y0), .busy(busy0), .done(done0), .signature(sig0));

    expr_vector_sequencer #(.DUT_LAT(2)) dut2 (
        .clk(clk), .reset(rst2), .start(start2), .abort(abort2), .num_vec(nv2), .seed(sd2),
        .stim(stim2), .stim_valid(sv2), .y(y2), .busy(busy2), .done(done2), .signature(sig2));

    // Datapath stand-in; junk while invalid so any stray capture shows up.
    function automatic logic [89:0] yfun(input logic [59:0] s, input logic v, input int mode);
        if (!v) return {3{30'h2AAAAAAA}};
        case (mode)
            0:       return 90'h0;
            1:       return 90'h1;
            2:       return {30'h0, s};
            default: return {s[29:0], s} ^ {s, s[59:30]} ^ 90'h5;
        endcase
    endfunction

    assign y0 = yfun(stim0, sv0, mode0);
    always_ff @(posedge clk) begin
        yp1 <= yfun(stim2, sv2, mode2);
        y2  <= yp1;
    end

    function automatic logic [63:0] lfsr_step(input logic [63:0] l);
        return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
    endfunction

    function automatic logic [89:0] model_sig(input logic [63:0] sd, input int n, input int mode);
        logic [63:0] l = (sd == 64'h0) ? 64'h1 : sd;
        logic [89:0] s = 90'h0;
        for (int i = 0; i < n; i++) begin
            s = {s[88:0], 1'b0} ^ (s[89] ? 90'h00D : 90'h0) ^ yfun(l[59:0], 1'b1, mode);
            l = lfsr_step(l);
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int lat, input logic st, input logic ab,
                         input logic [15:0] n, input logic [63:0] sd);
        if (lat == 0) begin
            start0 = st; abort0 = ab; nv0 = n; sd0 = sd;
        end else begin
            start2 = st; abort2 = ab; nv2 = n; sd2 = sd;
        end
    endtask

    // One complete run; poke re-asserts start mid-RUN, which must be ignored.
    task automatic run_check(input int lat, input logic [63:0] sd, input int n, input int mode,
                             input logic [89:0] exp_sig, input bit poke, input string nm);
        logic [63:0] l;
        logic [89:0] sig_at_done;
        logic        sv, bz, dn;
        logic [59:0] st;
        int stim_err, nvalid, nbusy, ndone, done_at, exp_done;
        if (lat == 0) mode0 = mode; else mode2 = mode;
        drive(lat, 1'b1, 1'b0, 16'(n), sd);
        step();
        drive(lat, 1'b0, 1'b0, 16'(n), sd);
        l = (sd == 64'h0) ? 64'h1 : sd;
        stim_err = 0; nvalid = 0; nbusy = 0; ndone = 0; done_at = -1;
        sig_at_done = 90'h0;
        exp_done = (n == 0) ? 0 : n + lat;
        for (int c = 0; c <= exp_done + 3; c++) begin
            sv = (lat == 0) ? sv0 : sv2;
            st = (lat == 0) ? stim0 : stim2;
            bz = (lat == 0) ? busy0 : busy2;
            dn = (lat == 0) ? done0 : done2;
            if (sv) begin
                if (st !== l[59:0]) stim_err++;
                l = lfsr_step(l);
                nvalid++;
            end
            if (bz) nbusy++;
            if (dn) begin
                ndone++;
                done_at = c;
                sig_at_done = (lat == 0) ? sig0 : sig2;
            end
            if (poke && (c == 1)) drive(lat, 1'b1, 1'b0, 16'd1, ~sd);
            if (poke && (c == 3)) drive(lat, 1'b0, 1'b0, 16'(n), sd);
            step();
        end
        chk({nm, " stim_seq_errors"}, stim_err, 0);
        chk({nm, " valid_count"}, nvalid, n);
        chk({nm, " busy_cycles"}, nbusy, exp_done);
        chk({nm, " done_count"}, ndone, 1);
        chk({nm, " done_cycle"}, done_at, exp_done);
        chk({nm, " signature"}, sig_at_done, exp_sig);
        chk({nm, " signature_hold"}, (lat == 0) ? sig0 : sig2, exp_sig);
    endtask

    // Abort on RUN cycle 'at' with a simultaneous start; neither done nor restart may follow.
    task automatic abort_check(input int n, input int at, input string nm);
        int extra;
        mode0 = 3;
        drive(0, 1'b1, 1'b0, 16'(n), 64'hBEEF);
        step();
        drive(0, 1'b0, 1'b0, 16'(n), 64'hBEEF);
        for (int c = 0; c < at; c++) step();
        drive(0, 1'b1, 1'b1, 16'(n), 64'h77);
        step();
        drive(0, 1'b0, 1'b0, 16'(n), 64'h77);
        chk({nm, " busy_after_abort"}, busy0, 1'b0);
        chk({nm, " valid_after_abort"}, sv0, 1'b0);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            extra += int'(done0) + int'(busy0) + int'(sv0);
            step();
        end
        chk({nm, " quiet_after_abort"}, extra, 0);
    endtask

    typedef struct {
        int          lat;
        logic [63:0] sd;
        int          n;
        int          mode;
        logic [89:0] exp_sig;
        bit          poke;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rs;
        int rn, rl;
        tbl.push_back('{0, 64'd1, 3, 0, 90'h0, 1'b0});
        tbl.push_back('{0, 64'd5, 2, 1, 90'h3, 1'b0});
        tbl.push_back('{0, 64'd9, 1, 1, 90'h1, 1'b0});
        tbl.push_back('{2, 64'h1234, 2, 2, model_sig(64'h1234, 2, 2), 1'b0});
        tbl.push_back('{0, 64'h1234, 2, 2, model_sig(64'h1234, 2, 2), 1'b0});
        tbl.push_back('{0, 64'd0, 1, 2, 90'h1, 1'b0});
        tbl.push_back('{0, 64'd7, 0, 3, 90'h0, 1'b0});
        tbl.push_back('{2, 64'd7, 0, 3, 90'h0, 1'b0});
        tbl.push_back('{0, 64'hC0FFEE, 8, 3, model_sig(64'hC0FFEE, 8, 3), 1'b1});
        for (int i = 0; i < 6; i++) begin
            rs = {$urandom, $urandom};
            rn = int'($urandom_range(40, 1));
            rl = ($urandom_range(1, 0) == 0) ? 0 : 2;
            tbl.push_back('{rl, rs, rn, 3, model_sig(rs, rn, 3), 1'b0});
        end
        tbl.push_back('{0, 64'hACE1, 65535, 3, model_sig(64'hACE1, 65535, 3), 1'b0});

        rst0 = 1'b1; rst2 = 1'b1;
        drive(0, 1'b0, 1'b0, 16'd0, 64'd0);
        drive(2, 1'b0, 1'b0, 16'd0, 64'd0);
        step(); step();
        rst0 = 1'b0; rst2 = 1'b0;
        chk("reset dut0 outputs", {stim0, sv0, busy0, done0}, 0);
        chk("reset dut0 signature", sig0, 90'h0);
        chk("reset dut2 outputs", {stim2, sv2, busy2, done2}, 0);
        chk("reset dut2 signature", sig2, 90'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_check(tbl[i].lat, tbl[i].sd, tbl[i].n, tbl[i].mode, tbl[i].exp_sig,
                      tbl[i].poke, $sformatf("vec%0d", i));
        end

        abort_check(10, 1, "abort_run2");
        run_check(0, 64'h55, 10, 3, model_sig(64'h55, 10, 3), 1'b0, "after_abort");
        abort_check(2, 1, "abort_last");

        // Reset in DRAIN, with start and abort also asserted on that edge.
        mode2 = 3;
        drive(2, 1'b1, 1'b0, 16'd3, 64'h99);
        step();
        drive(2, 1'b0, 1'b0, 16'd3, 64'h99);
        for (int c = 0; c < 3; c++) step();
        chk("drain busy", {busy2, sv2}, 2'b10);
        rst2 = 1'b1;
        drive(2, 1'b1, 1'b1, 16'd3, 64'h99);
        step();
        rst2 = 1'b0;
        drive(2, 1'b0, 1'b0, 16'd3, 64'h99);
        chk("reset_in_drain outputs", {stim2, sv2, busy2, done2}, 0);
        chk("reset_in_drain signature", sig2, 90'h0);
        step();
        chk("reset_in_drain stays idle", {sv2, busy2, done2}, 0);
        run_check(2, 64'h4321, 6, 3, model_sig(64'h4321, 6, 3), 1'b1, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
